handshake_constant_seq: RTL and testbench

Parametrised constant source for the dataflow netlist. Each accepted control token emits a fixed sequence of NUM_VALUES constants, one per output handshake, taken from a packed parameter table. The output is registered, so the block also cuts the combinational valid/data path from the control input to the output. It sits where single-value constant blocks would otherwise be chained, for example coefficient sequences feeding a softclip polynomial.

---
 rtl/handshake_constant_seq.sv | 79 +++++++
 tb/tb_handshake_constant_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
// Constant sequence source: every accepted control token emits NUM_VALUES
// constants from the packed VALUES table, one per output handshake. The
// output is fully registered, so valid/data never combinationally depend on
// the control input; only ctrl_ready looks at outs_ready combinationally.
module handshake_constant_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_VALUES = 4,
   parameter logic [NUM_VALUES*DATA_WIDTH-1:0] VALUES = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_last
);

   // Index width is at least one bit so the single-value build still has a
   // legal (constant zero) counter.
   localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

   // Table lookup: entry i lives at VALUES[i*DATA_WIDTH +: DATA_WIDTH].
   function automatic logic [DATA_WIDTH-1:0] table_entry(input logic [IDX_W-1:0] i);
      logic [NUM_VALUES*DATA_WIDTH-1:0] shifted;
      shifted = VALUES >> (int'(i) * DATA_WIDTH);
      return shifted[DATA_WIDTH-1:0];
   endfunction

   logic [DATA_WIDTH-1:0] outs_p0;
   logic                  vld_p0;
   logic [IDX_W-1:0]      idx_p0;

   logic                  last_p0;
   logic                  xfer;
   logic                  accept;
   logic [IDX_W-1:0]      idx_nxt;

   // Handshake decode: a new token is taken when idle, or in the very cycle
   // the final element of the current sequence leaves (no bubble). Reset
   // blocks acceptance so nothing is consumed while rst is high.
   always_comb begin
      last_p0    = (idx_p0 == LAST_IDX);
      xfer       = vld_p0 & outs_ready;
      ctrl_ready = ~rst & (~vld_p0 | (xfer & last_p0));
      accept     = ctrl_valid & ctrl_ready;
      idx_nxt    = idx_p0 + IDX_W'(1);
   end

   // Output register: load entry 0 on accept, step through the table on each
   // transfer, go idle after the last element; hold everything while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         idx_p0  <= '0;
         outs_p0 <= '0;
      end else if (accept) begin
         vld_p0  <= 1'b1;
         idx_p0  <= '0;
         outs_p0 <= table_entry('0);
      end else if (xfer) begin
         if (!last_p0) begin
            idx_p0  <= idx_nxt;
            outs_p0 <= table_entry(idx_nxt);
         end else begin
            vld_p0 <= 1'b0;
            idx_p0 <= '0;
         end
      end
   end

   assign outs       = outs_p0;
   assign outs_valid = vld_p0;
   assign outs_last  = vld_p0 & last_p0;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Testbench for handshake_constant_seq: a 3-entry build driven through
// directed scenarios and random traffic, plus a single-entry build under
// random traffic. Both are checked every cycle against a queue-based model.
module tb_handshake_constant_seq;

   localparam int DW = 8;
   localparam int NV = 3;
   localparam logic [NV*DW-1:0] VALS = {8'h33, 8'h22, 8'h11};
   localparam logic [DW-1:0]    VAL1 = 8'h5A;

   logic          clk = 1'b0;
   logic          rst, cv, ordy;
   logic          crdy, ovld, olast;
   logic [DW-1:0] outs;

   logic          rst1, cv1, ordy1;
   logic          crdy1, ovld1, olast1;
   logic [DW-1:0] outs1;

   int n_chk  = 0;
   int n_fail = 0;
   bit started = 0;

   always #5 clk = ~clk;

   handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_VALUES(NV), .VALUES(VALS)) dut (
      .clk(clk), .rst(rst), .ctrl_valid(cv), .ctrl_ready(crdy),
      .outs(outs), .outs_valid(ovld), .outs_ready(ordy), .outs_last(olast)
   );

   handshake_constant_seq #(.DATA_WIDTH(DW), .NUM_VALUES(1), .VALUES(VAL1)) dut1 (
      .clk(clk), .rst(rst1), .ctrl_valid(cv1), .ctrl_ready(crdy1),
      .outs(outs1), .outs_valid(ovld1), .outs_ready(ordy1), .outs_last(olast1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model of the 3-entry build: a queue of elements still to be shown;
   // the head is the current output, a single remaining element is the last.
   logic [DW-1:0] tab [NV] = '{8'h11, 8'h22, 8'h33};
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_outs = '0;

   function automatic bit m_ready(input bit r, input bit ready_in, input int sz);
      return !r && (sz == 0 || (ready_in && sz == 1));
   endfunction

   always @(posedge clk) begin
      bit rdy;
      if (rst) begin
         q.delete();
         m_outs = '0;
      end else begin
         rdy = m_ready(rst, ordy, q.size());
         if (q.size() != 0 && ordy) void'(q.pop_front());
         if (cv && rdy)
            for (int k = 0; k < NV; k++) q.push_back(tab[k]);
         if (q.size() != 0) m_outs = q[0];
      end
   end

   // Model of the single-entry build: one pending slot plus token/transfer counts.
   bit m_v1 = 0;
   int tok1 = 0;
   int xf1  = 0;

   always @(posedge clk) begin
      bit rdy1;
      if (rst1) begin
         m_v1 = 0;
      end else begin
         rdy1 = !m_v1 || ordy1;
         if (m_v1 && ordy1) begin
            xf1++;
            m_v1 = 0;
         end
         if (cv1 && rdy1) begin
            tok1++;
            m_v1 = 1;
         end
      end
   end

   // Per-cycle compare on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (started) begin
         chk("outs_valid", 32'(ovld), 32'(q.size() != 0));
         chk("outs", 32'(outs), 32'(m_outs));
         chk("outs_last", 32'(olast), 32'(q.size() == 1));
         chk("ctrl_ready", 32'(crdy), 32'(m_ready(rst, ordy, q.size())));
         chk("n1_outs_valid", 32'(ovld1), 32'(m_v1));
         chk("n1_ctrl_ready", 32'(crdy1), 32'(!rst1 && (!m_v1 || ordy1)));
         if (m_v1) begin
            chk("n1_outs", 32'(outs1), 32'(VAL1));
            chk("n1_outs_last", 32'(olast1), 32'd1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks 2 time units after an edge, once inputs for the next cycle are set.
   task automatic lit(input string nm, input bit v, input logic [DW-1:0] d,
                      input bit l, input bit r);
      #1;
      chk({nm, "_valid"}, 32'(ovld), 32'(v));
      if (v || nm == "reset") chk({nm, "_outs"}, 32'(outs), 32'(d));
      chk({nm, "_last"}, 32'(olast), 32'(l));
      chk({nm, "_ready"}, 32'(crdy), 32'(r));
   endtask

   initial begin
      rst = 1; cv = 0; ordy = 0;
      rst1 = 1; cv1 = 0; ordy1 = 0;
      tick();
      started = 1;
      tick();
      rst = 0; rst1 = 0;
      lit("reset", 0, 8'h00, 0, 1);

      // Single token with the consumer always ready.
      cv = 1; ordy = 1;
      tick(); cv = 0;
      lit("single0", 1, 8'h11, 0, 0);
      tick(); lit("single1", 1, 8'h22, 0, 0);
      tick(); lit("single2", 1, 8'h33, 1, 1);
      tick(); lit("single_end", 0, 8'h33, 0, 1);

      // Two back-to-back tokens: six consecutive valid cycles.
      cv = 1;
      tick(); lit("b2b0", 1, 8'h11, 0, 0);
      tick(); lit("b2b1", 1, 8'h22, 0, 0);
      tick(); lit("b2b2", 1, 8'h33, 1, 1);
      tick(); lit("b2b3", 1, 8'h11, 0, 0);
      tick(); lit("b2b4", 1, 8'h22, 0, 0);
      tick(); lit("b2b5", 1, 8'h33, 1, 1);
      cv = 0;
      tick(); lit("b2b_end", 0, 8'h33, 0, 1);

      // Backpressure on the middle element, with a token waiting.
      cv = 1;
      tick(); cv = 0;
      lit("bp0", 1, 8'h11, 0, 0);
      tick(); ordy = 0; cv = 1;
      lit("bp1", 1, 8'h22, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); lit("bp_hold", 1, 8'h22, 0, 0);
      end
      ordy = 1; cv = 0;
      tick(); lit("bp2", 1, 8'h33, 1, 1);
      tick(); lit("bp_end", 0, 8'h33, 0, 1);

      // Reset in the middle of a sequence, then restart from entry 0.
      cv = 1;
      tick(); cv = 0;
      tick(); rst = 1;
      lit("mid1", 1, 8'h22, 0, 0);
      tick(); lit("reset", 0, 8'h00, 0, 0);
      rst = 0; cv = 1;
      #1 chk("mid_ready_after", 32'(crdy), 32'd1);
      tick(); cv = 0;
      lit("restart", 1, 8'h11, 0, 0);
      tick(); tick(); tick();

      // Random traffic on both builds; occasional resets on the 3-entry one.
      for (int i = 0; i < 600; i++) begin
         cv    = ($urandom_range(0, 2) != 0);
         ordy  = ($urandom_range(0, 3) != 0);
         rst   = ($urandom_range(0, 60) == 0);
         cv1   = $urandom_range(0, 1) == 1;
         ordy1 = $urandom_range(0, 1) == 1;
         tick();
      end

      // Drain the single-entry build and balance tokens against transfers.
      rst = 0; cv = 0; ordy = 1;
      cv1 = 0; ordy1 = 1;
      repeat (4) tick();
      chk("n1_tokens_vs_xfers", 32'(tok1), 32'(xf1));
      #1 chk("n1_idle", 32'(ovld1), 32'd0);
      chk("n1_activity", 32'(tok1 > 20), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
